// File: rtl/sequential_arithmetic_logic_unit.sv
// Registered WIDTH-bit ALU with a Start/Busy/Done handshake. Logic, add and shift ops
// finish in one cycle; MUL/DIV/MOD iterate one bit per clock over WIDTH cycles.
module sequential_arithmetic_logic_unit #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [4:0]       FunSel,
  input  logic             WF,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [4:0] OP_PASS_A = 5'h00, OP_PASS_B = 5'h01, OP_NOT_A = 5'h02,
                         OP_NOT_B  = 5'h03, OP_ADD    = 5'h04, OP_ADC   = 5'h05,
                         OP_SUB    = 5'h06, OP_AND    = 5'h07, OP_OR    = 5'h08,
                         OP_XOR    = 5'h09, OP_NAND   = 5'h0A, OP_LSL   = 5'h0B,
                         OP_LSR    = 5'h0C, OP_ASR    = 5'h0D, OP_CSL   = 5'h0E,
                         OP_CSR    = 5'h0F, OP_MUL    = 5'h10, OP_DIV   = 5'h11,
                         OP_MOD    = 5'h12;

  typedef enum logic {IDLE, ITER} stateT;
  typedef enum logic [1:0] {M_MUL, M_DIV, M_MOD} multiT;

  stateT            state, stateNext;
  logic [CW-1:0]    count;
  multiT            multiOp;
  logic             wfLatched;
  logic [WIDTH-1:0] operand, hi, lo;

  function automatic logic signedOverflow(input logic aMsb, input logic bMsb, input logic rMsb);
    return (aMsb == bMsb) && (rMsb != aMsb);
  endfunction

  logic cIn, isMulti, lastStep;
  assign cIn      = FlagsOut[2];
  assign isMulti  = (FunSel == OP_MUL) || (FunSel == OP_DIV) || (FunSel == OP_MOD);
  assign lastStep = (state == ITER) && (count == CW'(WIDTH - 1));
  assign Busy     = (state == ITER);

  logic [WIDTH:0] addSum, adcSum, subSum;
  assign addSum = {1'b0, A} + {1'b0, B};
  assign adcSum = addSum + {{WIDTH{1'b0}}, cIn};
  assign subSum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] sRes;
  logic             sC, sO, sReserved;
  logic [3:0]       sFlags;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    sRes      = '0;
    sC        = FlagsOut[2];
    sO        = FlagsOut[0];
    sReserved = 1'b0;
    case (FunSel)
      OP_PASS_A: sRes = A;
      OP_PASS_B: sRes = B;
      OP_NOT_A:  sRes = ~A;
      OP_NOT_B:  sRes = ~B;
      OP_ADD: begin
        sRes = addSum[WIDTH-1:0];
        sC   = addSum[WIDTH];
        sO   = signedOverflow(A[WIDTH-1], B[WIDTH-1], addSum[WIDTH-1]);
      end
      OP_ADC: begin
        sRes = adcSum[WIDTH-1:0];
        sC   = adcSum[WIDTH];
        sO   = signedOverflow(A[WIDTH-1], B[WIDTH-1], adcSum[WIDTH-1]);
      end
      OP_SUB: begin
        sRes = subSum[WIDTH-1:0];
        sC   = subSum[WIDTH];
        sO   = signedOverflow(A[WIDTH-1], ~B[WIDTH-1], subSum[WIDTH-1]);
      end
      OP_AND:  sRes = A & B;
      OP_OR:   sRes = A | B;
      OP_XOR:  sRes = A ^ B;
      OP_NAND: sRes = ~(A & B);
      OP_LSL: begin sRes = {A[WIDTH-2:0], 1'b0};      sC = A[WIDTH-1]; end
      OP_LSR: begin sRes = {1'b0, A[WIDTH-1:1]};      sC = A[0];       end
      OP_ASR: begin sRes = {A[WIDTH-1], A[WIDTH-1:1]}; sC = A[0];      end
      OP_CSL: begin sRes = {A[WIDTH-2:0], cIn};       sC = A[WIDTH-1]; end
      OP_CSR: begin sRes = {cIn, A[WIDTH-1:1]};       sC = A[0];       end
      OP_MUL, OP_DIV, OP_MOD: ;
      default: sReserved = 1'b1;
    endcase
    sFlags = {~|sRes, sC, sRes[WIDTH-1], sO};
  end

  // One shift-add (MUL) or restoring shift-subtract (DIV/MOD) step on {hi, lo}.
  logic [WIDTH:0]   mulSum, divShift;
  logic             divFits;
  logic [WIDTH-1:0] divDiff, hiNext, loNext, iterRes;
  logic [3:0]       iterFlags;

  assign mulSum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
  assign divShift = {hi, lo[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, operand};
  assign divDiff  = divShift[WIDTH-1:0] - operand;

  always_comb begin
    hiNext    = hi;
    loNext    = lo;
    iterRes   = '0;
    iterFlags = FlagsOut;
    if (multiOp == M_MUL) begin
      hiNext    = mulSum[WIDTH:1];
      loNext    = {mulSum[0], lo[WIDTH-1:1]};
      iterRes   = loNext;
      iterFlags = {~|loNext, |hiNext, loNext[WIDTH-1], FlagsOut[0]};
    end else begin
      hiNext  = divFits ? divDiff : divShift[WIDTH-1:0];
      loNext  = {lo[WIDTH-2:0], divFits};
      iterRes = (multiOp == M_MOD) ? hiNext : loNext;
      if (operand == '0) begin
        iterRes   = '1;
        iterFlags = 4'b0011;
      end else begin
        iterFlags = {~|iterRes, FlagsOut[2], iterRes[WIDTH-1], 1'b0};
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (Start && isMulti) stateNext = ITER;
      ITER: if (lastStep)         stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ALUOut    <= '0;
      FlagsOut  <= '0;
      Done      <= 1'b0;
      count     <= '0;
      multiOp   <= M_MUL;
      wfLatched <= 1'b0;
      operand   <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE) begin
        if (Start && isMulti) begin
          count     <= '0;
          hi        <= '0;
          wfLatched <= WF;
          multiOp   <= (FunSel == OP_MUL) ? M_MUL : (FunSel == OP_DIV) ? M_DIV : M_MOD;
          operand   <= (FunSel == OP_MUL) ? A : B;
          lo        <= (FunSel == OP_MUL) ? B : A;
        end else if (Start) begin
          ALUOut <= sRes;
          if (WF && !sReserved) FlagsOut <= sFlags;
          Done <= 1'b1;
        end
      end else begin
        hi    <= hiNext;
        lo    <= loNext;
        count <= count + CW'(1);
        if (lastStep) begin
          ALUOut <= iterRes;
          if (wfLatched) FlagsOut <= iterFlags;
          Done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sequential_arithmetic_logic_unit.sv
// Directed bench for sequential_arithmetic_logic_unit: a vector table of single-cycle ops
// followed by hand-written multi-cycle, Start-while-Busy and mid-operation reset sequences.
module tb_sequential_arithmetic_logic_unit;

  localparam int WIDTH = 16;

  logic             Clock = 1'b0;
  logic             Reset, Start, WF;
  logic [4:0]       FunSel;
  logic [WIDTH-1:0] A, B, ALUOut;
  logic [3:0]       FlagsOut;
  logic             Busy, Done;

  sequential_arithmetic_logic_unit #(.WIDTH(WIDTH)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .FunSel(FunSel), .WF(WF),
    .A(A), .B(B), .ALUOut(ALUOut), .FlagsOut(FlagsOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  fs;
    logic        wf;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [3:0]  flags;   // {Z,C,N,O}
  } vecT;

  localparam int NVEC = 24;
  vecT vecs [NVEC];

  task automatic doMulti(input string name, input logic [4:0] fs, input logic wf,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] expOut, input logic [3:0] expFlags,
                         input int injectAt);
    int  n;
    logic seenDone, busyOk;
    @(negedge Clock);
    FunSel = fs; WF = wf; A = a; B = b; Start = 1'b1;
    @(posedge Clock); #1;
    check({name, "_busy_start"}, Busy, 1'b1);
    check({name, "_done_start"}, Done, 1'b0);
    n = 0; seenDone = 1'b0; busyOk = 1'b1;
    while (!seenDone && n < 40) begin
      @(negedge Clock);
      if (n == injectAt) begin
        FunSel = 5'h04; WF = 1'b1; A = 16'h0001; B = 16'h0001; Start = 1'b1;
      end else begin
        Start = 1'b0; A = ~a; B = 16'h5A5A; FunSel = 5'h00; WF = ~wf;
      end
      @(posedge Clock); #1;
      n++;
      if (Done) seenDone = 1'b1;
      else if (!Busy) busyOk = 1'b0;
    end
    check({name, "_latency"}, n, WIDTH);
    check({name, "_busy_held"}, busyOk, 1'b1);
    check({name, "_busy_end"}, Busy, 1'b0);
    check({name, "_out"}, ALUOut, expOut);
    check({name, "_flags"}, FlagsOut, expFlags);
  endtask

  initial begin
    vecs[0]  = '{5'h04, 1'b1, 16'h1234, 16'h4321, 16'h5555, 4'b0000};
    vecs[1]  = '{5'h04, 1'b1, 16'h7777, 16'h8889, 16'h0000, 4'b1100};
    vecs[2]  = '{5'h05, 1'b1, 16'h0000, 16'h0000, 16'h0001, 4'b0000};
    vecs[3]  = '{5'h04, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0000};
    vecs[4]  = '{5'h04, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011};
    vecs[5]  = '{5'h06, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 4'b0010};
    vecs[6]  = '{5'h06, 1'b1, 16'h0007, 16'h0005, 16'h0002, 4'b0100};
    vecs[7]  = '{5'h07, 1'b1, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0100};
    vecs[8]  = '{5'h09, 1'b1, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1100};
    vecs[9]  = '{5'h0A, 1'b1, 16'h00FF, 16'h0F0F, 16'hFFF0, 4'b0110};
    vecs[10] = '{5'h0B, 1'b1, 16'h8001, 16'h0000, 16'h0002, 4'b0100};
    vecs[11] = '{5'h0C, 1'b1, 16'h0001, 16'h0000, 16'h0000, 4'b1100};
    vecs[12] = '{5'h0D, 1'b1, 16'h8002, 16'h0000, 16'hC001, 4'b0010};
    vecs[13] = '{5'h0E, 1'b1, 16'h8000, 16'h0000, 16'h0000, 4'b1100};
    vecs[14] = '{5'h0F, 1'b1, 16'h0002, 16'h0000, 16'h8001, 4'b0010};
    vecs[15] = '{5'h02, 1'b1, 16'h00FF, 16'h0000, 16'hFF00, 4'b0010};
    vecs[16] = '{5'h01, 1'b1, 16'h1234, 16'h0000, 16'h0000, 4'b1000};
    vecs[17] = '{5'h08, 1'b0, 16'h1200, 16'h0034, 16'h1234, 4'b1000};
    vecs[18] = '{5'h1F, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000};
    vecs[19] = '{5'h04, 1'b1, 16'h8000, 16'h8000, 16'h0000, 4'b1101};
    vecs[20] = '{5'h00, 1'b1, 16'h8000, 16'h0000, 16'h8000, 4'b0111};
    vecs[21] = '{5'h03, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 4'b1101};
    vecs[22] = '{5'h06, 1'b1, 16'h1234, 16'h1234, 16'h0000, 4'b1100};
    vecs[23] = '{5'h04, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011};

    Reset = 1'b1; Start = 1'b0; WF = 1'b0; FunSel = '0; A = '0; B = '0;
    #2 Reset = 1'b0;
    #10;
    check("reset_out", ALUOut, 16'h0000);
    check("reset_flags", FlagsOut, 4'b0000);
    check("reset_busy", Busy, 1'b0);
    check("reset_done", Done, 1'b0);
    @(negedge Clock); Reset = 1'b1;

    // Start stays high across the table, so single-cycle ops issue every cycle.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge Clock);
      FunSel = vecs[i].fs; WF = vecs[i].wf; A = vecs[i].a; B = vecs[i].b; Start = 1'b1;
      @(posedge Clock); #1;
      check($sformatf("v%0d_out", i), ALUOut, vecs[i].out);
      check($sformatf("v%0d_flags", i), FlagsOut, vecs[i].flags);
      check($sformatf("v%0d_done", i), Done, 1'b1);
      check($sformatf("v%0d_busy", i), Busy, 1'b0);
    end
    @(negedge Clock); Start = 1'b0;
    @(posedge Clock); #1;
    check("done_drops", Done, 1'b0);

    doMulti("mul_0100",  5'h10, 1'b1, 16'h0100, 16'h0100, 16'h0000, 4'b1101, 3);
    doMulti("mul_ffff",  5'h10, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0101, -1);
    doMulti("div_100_7", 5'h11, 1'b1, 16'h0064, 16'h0007, 16'h000E, 4'b0100, WIDTH - 1);
    doMulti("mod_100_7", 5'h12, 1'b1, 16'h0064, 16'h0007, 16'h0002, 4'b0100, -1);
    doMulti("div_by_0",  5'h11, 1'b1, 16'h1234, 16'h0000, 16'hFFFF, 4'b0011, -1);
    doMulti("mod_by_0",  5'h12, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 4'b0011, -1);

    // Reset five cycles into a MUL must clear everything at once and leave no late write.
    @(negedge Clock);
    FunSel = 5'h10; WF = 1'b1; A = 16'h0100; B = 16'h0100; Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock); Start = 1'b0;
    repeat (4) @(posedge Clock);
    #1 Reset = 1'b0;
    #1;
    check("abort_out", ALUOut, 16'h0000);
    check("abort_flags", FlagsOut, 4'b0000);
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    @(negedge Clock); Reset = 1'b1;
    begin
      logic quiet;
      quiet = 1'b1;
      repeat (20) begin
        @(posedge Clock); #1;
        if (Done || Busy || ALUOut != 16'h0000 || FlagsOut != 4'b0000) quiet = 1'b0;
      end
      check("abort_no_late_write", quiet, 1'b1);
    end
    @(negedge Clock);
    FunSel = 5'h04; WF = 1'b1; A = 16'h0001; B = 16'h0001; Start = 1'b1;
    @(posedge Clock); #1;
    check("post_reset_add_out", ALUOut, 16'h0002);
    check("post_reset_add_flags", FlagsOut, 4'b0000);
    check("post_reset_add_done", Done, 1'b1);
    @(negedge Clock); Start = 1'b0;
    @(posedge Clock); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sequential_arithmetic_logic_unit.md
# sequential_arithmetic_logic_unit

Parametrised, registered successor to the 16-bit ALU: WIDTH-bit datapath with a Start/Busy/Done handshake, single-cycle logic/arithmetic/shift operations, and iterative multi-cycle unsigned multiply, divide and modulo. Sits between the register file / address register outputs and the bus mux. ALUOut and the {Z,C,N,O} flag register are both held until the next completed operation.

## Interface
- WIDTH, 16, datapath width in bits (≥4)
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request; accepted on a rising edge while Busy=0
- FunSel  in  5  operation select, latched at acceptance
- WF  in  1  flag write enable, latched at acceptance
- A  in  WIDTH  operand A, latched at acceptance
- B  in  WIDTH  operand B, latched at acceptance
- ALUOut  out  WIDTH  registered result
- FlagsOut  out  4  registered {Z,C,N,O}
- Busy  out  1  multi-cycle operation in progress
- Done  out  1  one-cycle pulse: result and flags are valid

## Operation
- FunSel codes: 00000 A; 00001 B; 00010 ~A; 00011 ~B; 00100 A+B; 00101 A+B+C; 00110 A−B (A+~B+1); 00111 A&B; 01000 A|B; 01001 A^B; 01010 ~(A&B); 01011 LSL A; 01100 LSR A; 01101 ASR A; 01110 CSL A (through C); 01111 CSR A (through C); 10000 MUL; 10001 DIV; 10010 MOD; all other codes reserved.
- C used by ADC/CSL/CSR is the FlagsOut value at the acceptance edge.
- Flags are written only if the latched WF=1. Otherwise all four bits hold.
- Z = (result==0) and N = result[WIDTH-1] for every non-reserved op.
- Add/sub: C = carry out of bit WIDTH-1 (sub: carry of A+~B+1). O = signed overflow.
- Shifts: C = the bit shifted out. O holds.
- Pass/NOT/logic: C and O hold.
- MUL: unsigned; ALUOut = low WIDTH bits of A*B; C = 1 if the high WIDTH bits are nonzero; O holds.
- DIV/MOD: unsigned quotient/remainder, computed by restoring division.
  - B≠0: O=0, C holds.
  - B=0: ALUOut = all ones, O=1, C=0.
- Reserved codes: ALUOut=0, flags hold regardless of WF, Done still pulses.
- States: IDLE, ITER.
  - IDLE + Start with single-cycle op: compute, register ALUOut/flags, pulse Done, remain in IDLE.
  - IDLE + Start with MUL/DIV/MOD: load the working registers and iteration counter=0, go to ITER, Busy=1.
  - ITER: one shift-add or shift-subtract step per edge. On the step where counter=WIDTH-1, write ALUOut/flags, pulse Done, and return to IDLE.
- Start while Busy=1 is ignored and is not queued.

## Timing
- Reset (Reset=0, asynchronous): ALUOut=0, FlagsOut=0000, Busy=0, Done=0, state IDLE, counter=0.
- Reset asserted mid-ITER aborts the operation. No result or flag write occurs after release.
- Single-cycle op accepted at edge k: ALUOut/FlagsOut update at edge k, Done=1 for the cycle after edge k, Busy stays 0.
- Multi-cycle op accepted at edge k:
  - Busy=1 from after edge k through edge k+WIDTH.
  - ALUOut/FlagsOut update at edge k+WIDTH.
  - Done=1 for the cycle after edge k+WIDTH.
  - Latency is WIDTH cycles.
- Back-to-back: Start is accepted during the cycle in which Done=1, because Busy is already 0. Single-cycle ops can therefore issue every cycle.
- A/B/FunSel/WF may change freely after acceptance without affecting the operation in flight.
- Width rules: all internal arithmetic is WIDTH+1 bits for carry. MUL uses a 2·WIDTH accumulator. Counter width is clog2(WIDTH).

## Test plan
- WIDTH=16, after reset: A=1234, B=4321, FunSel=00100, WF=1, Start for 1 cycle -> ALUOut=5555, FlagsOut=0000, Done for 1 cycle, Busy never 1.
- A=7777, B=8889, ADD, WF=1 -> ALUOut=0000, Z=1 C=1 N=0 O=0. Then ADC with A=0000, B=0000 -> ALUOut=0001, Z=0 C=0.
- Flags 0000, A=7FFF, B=0001, ADD, WF=0 -> ALUOut=8000, FlagsOut stays 0000. Repeat with WF=1 -> N=1, O=1, Z=0, C=0.
- MUL A=0100, B=0100 -> Busy high for 16 cycles, then ALUOut=0000, Z=1, C=1. A Start pulsed with ADD mid-Busy is ignored.
- DIV A=0064, B=0007 -> 000E. MOD with the same operands -> 0002. DIV with B=0000 -> ALUOut=FFFF, O=1, C=0, N=1, Z=0.
- Reset asserted 5 cycles into a MUL -> all outputs 0 immediately. After release, ADD 0001+0001 -> 0002 with Done after 1 edge.
